// File: rtl/onchip_ram_pkg.sv
// rtl/onchip_ram_pkg.sv - shared state type, limits and helpers for onchip_ram_pipelined
package onchip_ram_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int READ_LATENCY_MAX = 2;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// rtl/onchip_ram_core.sv - single-port byte-lane RAM, synchronous read, clock enable
module onchip_ram_core #(
  parameter int NUM_BYTES  = 4,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 en,
  input  logic [ADDR_WIDTH-1:0]                addr,
  input  logic [NUM_BYTES-1:0]                 byte_we,
  input  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] wdata,
  output logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] rdata
);

  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (byte_we[i]) mem[addr][i] <= wdata[i];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/onchip_ram_pipelined.sv
// rtl/onchip_ram_pipelined.sv - Avalon-MM RAM slave with read pipeline and zero-fill; ONCHIP_RAM_PARITY_EN adds byte parity
module onchip_ram_pipelined
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 10000,
  parameter int ADDR_WIDTH     = 14,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     writedata,
  input  logic                      clken,
  input  logic                      reset_req,
  output logic                      waitrequest,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      readdatavalid,
  output logic                      init_done
`ifdef ONCHIP_RAM_PARITY_EN
  ,
  output logic                      parity_err
`endif
);

  localparam int NB    = bytes_of(DATA_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ONCHIP_RAM_PARITY_EN
  localparam int BW = 9;
`else
  localparam int BW = 8;
`endif
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  logic                 en;
  state_t               state, state_nxt;
  logic [IDX_W-1:0]     init_cnt, init_cnt_nxt;
  logic                 in_range, req, wr_acc, rd_acc;
  logic [IDX_W-1:0]     ram_addr;
  logic [NB-1:0]        ram_we;
  logic [NB-1:0][BW-1:0] ram_wdata, ram_rdata;
  logic                 s1_valid, s1_zero;
  logic [DATA_WIDTH-1:0] s1_data;
`ifdef ONCHIP_RAM_PARITY_EN
  logic                 s1_perr;
`endif

  assign en          = clken & ~reset_req;
  assign waitrequest = ~en | (state != ST_RUN);
  assign init_done   = (state == ST_RUN);
  assign in_range    = {1'b0, address} < DEPTH_W;
  assign req         = chipselect & (read | write) & ~waitrequest & ~reset;
  assign wr_acc      = req & write;
  assign rd_acc      = req & read & ~write;

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    if (state == ST_INIT) begin
      init_cnt_nxt = init_cnt + 1'b1;
      if (init_cnt == LAST_IDX) state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RESET_STATE;
      init_cnt <= '0;
    end else if (en) begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // The fill engine borrows the single RAM port while the bus is stalled.
  always_comb begin
    ram_addr = address[IDX_W-1:0];
    ram_we   = '0;
    for (int i = 0; i < NB; i++) begin
`ifdef ONCHIP_RAM_PARITY_EN
      ram_wdata[i] = {^writedata[i*8 +: 8], writedata[i*8 +: 8]};
`else
      ram_wdata[i] = writedata[i*8 +: 8];
`endif
    end
    if (state == ST_INIT) begin
      ram_addr  = init_cnt;
      ram_we    = '1;
      ram_wdata = '0;
    end else if (wr_acc && in_range) begin
      ram_we = byteenable;
    end
  end

  onchip_ram_core #(
    .NUM_BYTES (NB),
    .BYTE_WIDTH(BW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(IDX_W)
  ) u_core (
    .clk    (clk),
    .en     (en & ~reset),
    .addr   (ram_addr),
    .byte_we(ram_we),
    .wdata  (ram_wdata),
    .rdata  (ram_rdata)
  );

  // s1_zero masks the RAM output for idle slots, out-of-range reads and reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b1;
    end else if (en) begin
      s1_valid <= rd_acc;
      s1_zero  <= ~(rd_acc & in_range);
    end
  end

  always_comb begin
    s1_data = '0;
`ifdef ONCHIP_RAM_PARITY_EN
    s1_perr = 1'b0;
`endif
    for (int i = 0; i < NB; i++) begin
      if (!s1_zero) s1_data[i*8 +: 8] = ram_rdata[i][7:0];
`ifdef ONCHIP_RAM_PARITY_EN
      if (!s1_zero && (^ram_rdata[i])) s1_perr = 1'b1;
`endif
    end
  end

  generate
    if (READ_LATENCY >= READ_LATENCY_MAX) begin : g_lat2
      always_ff @(posedge clk) begin
        if (reset) begin
          readdatavalid <= 1'b0;
          readdata      <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
          parity_err    <= 1'b0;
`endif
        end else if (en) begin
          readdatavalid <= s1_valid;
          readdata      <= s1_data;
`ifdef ONCHIP_RAM_PARITY_EN
          parity_err    <= s1_perr;
`endif
        end
      end
    end else begin : g_lat1
      assign readdatavalid = s1_valid;
      assign readdata      = s1_data;
`ifdef ONCHIP_RAM_PARITY_EN
      assign parity_err    = s1_perr;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// tb/tb_onchip_ram_pipelined.sv - self-checking bench: cleared/latency-2 instance beside a plain/latency-1 instance
module tb_onchip_ram_pipelined;

  localparam int DW = 32;
  localparam int AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, chipselect, read, write, clken, reset_req;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic [DW-1:0] writedata;
  logic          wr0, rdv0, idone0, wr1, rdv1, idone1;
  logic [DW-1:0] rdata0, rdata1;
`ifdef ONCHIP_RAM_PARITY_EN
  logic          perr0, perr1;
`endif

  onchip_ram_pipelined #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(14), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .waitrequest(wr0), .readdata(rdata0),
    .readdatavalid(rdv0), .init_done(idone0)
`ifdef ONCHIP_RAM_PARITY_EN
    , .parity_err(perr0)
`endif
  );

  onchip_ram_pipelined #(
    .DATA_WIDTH(32), .DEPTH(10000), .ADDR_WIDTH(14), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
  ) dut1 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .waitrequest(wr1), .readdata(rdata1),
    .readdatavalid(rdv1), .init_done(idone1)
`ifdef ONCHIP_RAM_PARITY_EN
    , .parity_err(perr1)
`endif
  );

  typedef struct {
    logic [31:0] d;
    bit          care1;
  } exp_t;

  typedef struct {
    bit          w;
    bit          r;
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] e;
    bit          c1;
  } vec_t;

  logic [31:0] q0[$];
  exp_t        q1[$];
  exp_t        e1;
  vec_t        tbl[$];
  int          errors = 0;
  int          checks = 0;
  bit          last_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Only a readdatavalid produced by an enabled edge is a new response.
  always @(negedge clk) begin
    if (last_en) begin
      if (rdv0) begin
        if (q0.size() == 0) check("rdv0_unexpected", 32'd1, 32'd0);
        else check("rdata0", rdata0, q0.pop_front());
      end
      if (rdv1) begin
        if (q1.size() == 0) check("rdv1_unexpected", 32'd1, 32'd0);
        else begin
          e1 = q1.pop_front();
          if (e1.care1) check("rdata1", rdata1, e1.d);
        end
      end
    end
    last_en = clken & ~reset_req & ~reset;
  end

  task automatic drive(input bit w, input bit r, input logic [13:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] e, input bit c1);
    @(posedge clk); #1;
    chipselect = w | r; write = w; read = r;
    address = a; byteenable = be; writedata = wd;
    if (r && !w) begin
      q0.push_back(e);
      q1.push_back('{d: e, care1: c1});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 14'd0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic init_count(input string name);
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (idone0) done = 1'b1;
      else if (wr0) n++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_wait_cycles"}, n, 32'd16);
    check({name, "_wait_after"}, 32'(wr0), 32'd0);
  endtask

  initial begin
    bit          lat_v0[6]    = '{0, 0, 1, 1, 1, 0};
    bit          lat_v1[6]    = '{0, 1, 1, 1, 0, 0};
    logic [31:0] lat_exp[3]   = '{32'h0, 32'h11111111, 32'h22222222};
    bit          frz_v0[7]    = '{0, 0, 0, 0, 0, 1, 0};
    bit          frz_v1[7]    = '{0, 1, 1, 1, 1, 0, 0};

    tbl.push_back('{1, 0, 14'd5,     4'hF, 32'hDEADBEEF, 32'h0,        0});
    tbl.push_back('{1, 0, 14'd5,     4'h1, 32'h000000AA, 32'h0,        0});
    tbl.push_back('{0, 1, 14'd5,     4'h0, 32'h0,        32'hDEADBEAA, 1});
    tbl.push_back('{1, 0, 14'd3,     4'hF, 32'h11223344, 32'h0,        0});
    tbl.push_back('{1, 0, 14'd3,     4'h6, 32'hAABBCCDD, 32'h0,        0});
    tbl.push_back('{0, 1, 14'd3,     4'h0, 32'h0,        32'h11BBCC44, 1});
    tbl.push_back('{1, 0, 14'd7,     4'hF, 32'h0A0B0C0D, 32'h0,        0});
    tbl.push_back('{1, 0, 14'd7,     4'h0, 32'hFFFFFFFF, 32'h0,        0});
    tbl.push_back('{0, 1, 14'd7,     4'h0, 32'h0,        32'h0A0B0C0D, 1});
    tbl.push_back('{1, 0, 14'd9,     4'hF, 32'h55AA55AA, 32'h0,        0});
    tbl.push_back('{0, 1, 14'd9,     4'h0, 32'h0,        32'h55AA55AA, 1});
    tbl.push_back('{1, 1, 14'd9,     4'hF, 32'h01020304, 32'h0,        0});
    tbl.push_back('{0, 1, 14'd9,     4'h0, 32'h0,        32'h01020304, 1});
    tbl.push_back('{1, 0, 14'd0,     4'hF, 32'h0,        32'h0,        0});
    tbl.push_back('{1, 0, 14'd15,    4'hF, 32'hCAFEF00D, 32'h0,        0});
    tbl.push_back('{1, 0, 14'd10000, 4'hF, 32'hFFFFFFFF, 32'h0,        0});
    tbl.push_back('{0, 1, 14'd10000, 4'h0, 32'h0,        32'h0,        1});
    tbl.push_back('{0, 1, 14'd0,     4'h0, 32'h0,        32'h0,        1});
    tbl.push_back('{0, 1, 14'd15,    4'h0, 32'h0,        32'hCAFEF00D, 1});
    tbl.push_back('{0, 1, 14'd16383, 4'h0, 32'h0,        32'h0,        1});
    tbl.push_back('{1, 0, 14'd1,     4'hF, 32'h11111111, 32'h0,        0});
    tbl.push_back('{1, 0, 14'd2,     4'hF, 32'h22222222, 32'h0,        0});

    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wait0",  32'(wr0),    32'd1);
    check("rst_idone0", 32'(idone0), 32'd0);
    check("rst_rdv0",   32'(rdv0),   32'd0);
    check("rst_rdata0", rdata0,      32'd0);
    check("rst_wait1",  32'(wr1),    32'd0);
    check("rst_idone1", 32'(idone1), 32'd1);
    check("rst_rdv1",   32'(rdv1),   32'd0);
    check("rst_rdata1", rdata1,      32'd0);

    @(posedge clk); #1; reset = 1'b0;
    init_count("init");

    for (int a = 0; a < 16; a++) drive(1'b0, 1'b1, 14'(a), 4'h0, 32'h0, 32'h0, 1'b0);
    idle(4);

    foreach (tbl[i]) drive(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].be, tbl[i].wd, tbl[i].e, tbl[i].c1);
    idle(4);

    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1'b0, 1'b1, 14'(i), 4'h0, 32'h0, lat_exp[i], 1'b1);
      else idle(1);
      @(negedge clk);
      check($sformatf("lat2_rdv_%0d", i), 32'(rdv0), 32'(lat_v0[i]));
      check($sformatf("lat1_rdv_%0d", i), 32'(rdv1), 32'(lat_v1[i]));
    end
    idle(3);

    for (int i = 0; i < 7; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 14'd5, 4'h0, 32'h0, 32'hDEADBEAA, 1'b1);
      else idle(1);
      clken     = !(i == 1 || i == 3);
      reset_req = (i == 2);
      @(negedge clk);
      check($sformatf("frz_rdv0_%0d", i), 32'(rdv0), 32'(frz_v0[i]));
      check($sformatf("frz_rdv1_%0d", i), 32'(rdv1), 32'(frz_v1[i]));
      if (i >= 1 && i <= 3) begin
        check($sformatf("frz_wait0_%0d", i), 32'(wr0), 32'd1);
        check($sformatf("frz_wait1_%0d", i), 32'(wr1), 32'd1);
      end
      if (i >= 1 && i <= 4) check($sformatf("frz_hold1_%0d", i), rdata1, 32'hDEADBEAA);
    end
    idle(3);

    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    repeat (7) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    init_count("reinit");
    drive(1'b0, 1'b1, 14'd5, 4'h0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 14'd15, 4'h0, 32'h0, 32'h0, 1'b0);
    idle(4);

`ifdef ONCHIP_RAM_PARITY_EN
    begin
      bit seen = 1'b0;
      drive(1'b1, 1'b0, 14'd4, 4'hF, 32'h12345678, 32'h0, 1'b0);
      idle(2);
      dut.u_core.mem[4][0][0] = ~dut.u_core.mem[4][0][0];
      drive(1'b0, 1'b1, 14'd4, 4'h0, 32'h0, 32'h12345679, 1'b0);
      idle(1);
      for (int i = 0; i < 6 && !seen; i++) begin
        @(negedge clk);
        if (rdv0) begin
          seen = 1'b1;
          check("parity_err", 32'(perr0), 32'd1);
        end
      end
      check("parity_seen", 32'(seen), 32'd1);
      idle(3);
    end
`endif

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule

// File: doc/onchip_ram_pipelined.md
Name: onchip_ram_pipelined

Overview:
Parametrised Avalon-MM on-chip RAM slave; successor to the fixed 32-bit, single-port, unregistered on-chip memory. Adds the following generalisations and behaviours:
- generic data width and depth;
- configurable read latency with readdatavalid;
- waitrequest-based stalling;
- an optional post-reset zero-fill engine.
Sits on the system interconnect as program/data memory for the soft processor and ADC capture buffers.

Parameters:
DATA_WIDTH, 32, data bus width; multiple of 8.
DEPTH, 10000, number of words.
ADDR_WIDTH, 14, address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
CLEAR_ON_RESET, 0, 1 = zero-fill every word after reset before accepting transfers.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
address  in  ADDR_WIDTH  word address.
byteenable  in  DATA_WIDTH/8  per-byte write enable.
chipselect  in  1  slave select.
read  in  1  read request.
write  in  1  write request.
writedata  in  DATA_WIDTH  write data.
clken  in  1  clock enable; low freezes the block.
reset_req  in  1  reset-pending request; treated as clken low.
waitrequest  out  1  transfer not accepted this cycle.
readdata  out  DATA_WIDTH  read data.
readdatavalid  out  1  readdata valid this cycle.
init_done  out  1  memory ready for transfers.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high. All state is updated on the rising clk edge.
- Reset values: readdatavalid=0, readdata=0, pipeline cleared.
  - CLEAR_ON_RESET=1: waitrequest=1, init_done=0.
  - CLEAR_ON_RESET=0: waitrequest=0, init_done=1.
- Enable: en = clken & ~reset_req. With en=0:
  - no state, RAM or pipeline stage changes;
  - waitrequest=1;
  - readdata and readdatavalid hold their values.
- FSM (two states):
  - INIT (only when CLEAR_ON_RESET=1): a counter writes 0 to word 0..DEPTH-1, one word per enabled cycle. After word DEPTH-1 is written, go to RUN.
  - RUN: normal operation; init_done=1.
  - Reset asserted in any state restarts INIT from word 0.
- Accept rule: a transfer is accepted when chipselect & (read|write) & ~waitrequest. In RUN with en=1, waitrequest=0, so back-to-back transfers proceed at one per cycle.
- Write:
  - Bytes with byteenable[i]=1 are updated at the accept edge; other bytes keep their value.
  - byteenable=0 is a legal no-op.
- Read:
  - Synchronous RAM read.
  - READ_LATENCY=1: readdatavalid and readdata are presented on the cycle after accept.
  - READ_LATENCY=2: an extra output register adds one cycle.
  - Fully pipelined; one read accepted per cycle.
- Simultaneous read and write: write wins; the read is dropped and no readdatavalid is produced.
- Read following a write to the same address on the next cycle returns the new data.
- Out-of-range address (address >= DEPTH):
  - write is discarded;
  - read returns all zeros with a normal readdatavalid.
- Reads issued while waitrequest=1 are not accepted; the master must hold the request.

Optional Feature:
Macro ONCHIP_RAM_PARITY_EN.
- Defined:
  - one even-parity bit is stored per byte, written with its byte;
  - on read, parity is recomputed and output parity_err (1 bit) is asserted together with readdatavalid when any byte mismatches;
  - parity_err resets to 0;
  - the INIT fill writes parity 0.
- Undefined: no parity storage and no parity_err port.

Decomposition:
- Package onchip_ram_pkg holds:
  - state typedef {ST_INIT, ST_RUN};
  - function bytes_of(DATA_WIDTH);
  - localparam READ_LATENCY_MAX=2.
- Sub-module onchip_ram_core: inferred single-port byte-enable RAM with synchronous read and a clock enable. The top level owns the FSM, init counter, range check, read pipeline and parity logic.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16: release reset -> waitrequest=1 for exactly 16 cycles, init_done=1 on cycle 17; a read of every address returns 0.
- Write 0xDEADBEEF to address 5 with byteenable=4'b1111, then 0x000000AA with byteenable=4'b0001, then read address 5 -> readdata=0xDEADBEAA.
- READ_LATENCY=2, reads of addresses 0,1,2 on consecutive cycles -> readdatavalid high on cycles t+2, t+3, t+4 with the matching data, and no gaps.
- clken=0 for 3 cycles while a read is in flight -> waitrequest=1, readdatavalid frozen; the data appears after clken returns, with latency extended by 3 cycles.
- Write to address 10000 then read address 10000 (DEPTH=10000) -> no RAM word changes, readdata=0, readdatavalid=1.
- Reset asserted midway through INIT -> the counter restarts from 0 and init_done rises DEPTH cycles after reset is released. With ONCHIP_RAM_PARITY_EN defined, force a flipped bit in a stored byte -> parity_err=1 alongside readdatavalid.
